// File: rtl/univ_register.sv
// Universal WIDTH-bit register: load, shift, rotate, inc/dec with carry/zero.
// Optional registered even-parity output enabled by defining UREG_PARITY_EN.
module univ_register #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             carry,
`ifdef UREG_PARITY_EN
    output logic             parity,
`endif
    output logic             zero
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_INC  = 3'b110,
        M_DEC  = 3'b111
    } mode_e;

    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    logic [WIDTH-1:0] nxt_out;
    logic             nxt_carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // Extra top bit holds carry-out of INC and borrow of DEC.
    assign sum  = {1'b0, out} + ONE;
    assign diff = {1'b0, out} - ONE;

    always_comb begin
        nxt_out   = out;
        nxt_carry = carry;
        if (en) begin
            unique case (mode_e'(mode))
                M_HOLD: begin
                    nxt_out   = out;
                    nxt_carry = carry;
                end
                M_LOAD: begin
                    nxt_out   = data;
                    nxt_carry = 1'b0;
                end
                M_SHL: begin
                    nxt_out   = {out[WIDTH-2:0], sin};
                    nxt_carry = out[WIDTH-1];
                end
                M_SHR: begin
                    nxt_out   = {sin, out[WIDTH-1:1]};
                    nxt_carry = out[0];
                end
                M_ROL: begin
                    nxt_out   = {out[WIDTH-2:0], out[WIDTH-1]};
                    nxt_carry = out[WIDTH-1];
                end
                M_ROR: begin
                    nxt_out   = {out[0], out[WIDTH-1:1]};
                    nxt_carry = out[0];
                end
                M_INC: begin
                    nxt_out   = sum[WIDTH-1:0];
                    nxt_carry = sum[WIDTH];
                end
                M_DEC: begin
                    nxt_out   = diff[WIDTH-1:0];
                    nxt_carry = diff[WIDTH];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out   <= RST_VAL;
            carry <= 1'b0;
        end else begin
            out   <= nxt_out;
            carry <= nxt_carry;
        end
    end

`ifdef UREG_PARITY_EN
    // nxt_out equals out whenever the register holds, so parity holds too.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            parity <= ^RST_VAL;
        end else begin
            parity <= ^nxt_out;
        end
    end
`endif

    assign zero = ~|out;

endmodule

// File: tb/tb_univ_register.sv
// Scoreboard bench for univ_register (WIDTH=8, RST_VAL=0).
module tb_univ_register;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] ROL  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;
    localparam logic [2:0] INC  = 3'b110;
    localparam logic [2:0] DEC  = 3'b111;

    typedef struct {
        logic [7:0] out;
        logic       carry;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_;
    logic       en;
    logic [2:0] mode;
    logic [7:0] data;
    logic       sin;
    logic [7:0] out;
    logic       carry;
    logic       zero;

    int total = 0;
    int bad   = 0;
    exp_t q[$];

`ifdef UREG_PARITY_EN
    logic       parity;
    logic [7:0] out3;
    logic       carry3;
    logic       zero3;
    logic       parity3;
`endif

    univ_register #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk    (clk),
        .rst_   (rst_),
        .en     (en),
        .mode   (mode),
        .data   (data),
        .sin    (sin),
        .out    (out),
        .carry  (carry),
`ifdef UREG_PARITY_EN
        .parity (parity),
`endif
        .zero   (zero)
    );

`ifdef UREG_PARITY_EN
    univ_register #(.WIDTH(8), .RST_VAL(8'h03)) dut3 (
        .clk    (clk),
        .rst_   (rst_),
        .en     (1'b0),
        .mode   (HOLD),
        .data   (8'h00),
        .sin    (1'b0),
        .out    (out3),
        .carry  (carry3),
        .parity (parity3),
        .zero   (zero3)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic op(input logic e, input logic [2:0] m,
                      input logic [7:0] d, input logic s,
                      input logic [7:0] eo, input logic ec,
                      input string nm);
        exp_t x;
        @(negedge clk);
        en   = e;
        mode = m;
        data = d;
        sin  = s;
        x.out   = eo;
        x.carry = ec;
        x.name  = nm;
        q.push_back(x);
    endtask

    // Monitor: one registered result per clock edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk({x.name, ".out"}, out, x.out);
                chk({x.name, ".carry"}, {7'd0, carry}, {7'd0, x.carry});
                chk({x.name, ".zero"}, {7'd0, zero},
                    {7'd0, (x.out == 8'h00)});
`ifdef UREG_PARITY_EN
                chk({x.name, ".parity"}, {7'd0, parity},
                    {7'd0, ^x.out});
`endif
            end
        end
    end

    initial begin
        rst_ = 1'b0;
        en   = 1'b0;
        mode = HOLD;
        data = 8'h00;
        sin  = 1'b0;
        #2;
        chk("rst.out", out, 8'h00);
        chk("rst.carry", {7'd0, carry}, 8'h00);
        chk("rst.zero", {7'd0, zero}, 8'h01);
`ifdef UREG_PARITY_EN
        chk("rst.parity", {7'd0, parity}, 8'h00);
        chk("rst3.out", out3, 8'h03);
        chk("rst3.parity", {7'd0, parity3}, 8'h00);
`endif
        @(negedge clk);
        rst_ = 1'b1;

        op(1, LOAD, 8'hA5, 0, 8'hA5, 0, "ld_a5");
        op(0, INC,  8'h00, 0, 8'hA5, 0, "hold1");
        op(0, INC,  8'h00, 0, 8'hA5, 0, "hold2");
        op(0, INC,  8'h00, 0, 8'hA5, 0, "hold3");

        op(1, LOAD, 8'h81, 0, 8'h81, 0, "ld_81");
        op(1, SHL,  8'h00, 0, 8'h02, 1, "shl");
        op(0, LOAD, 8'h55, 1, 8'h02, 1, "hold_c");
        op(1, SHR,  8'h00, 1, 8'h81, 0, "shr");

        op(1, LOAD, 8'h01, 0, 8'h01, 0, "ld_01");
        op(1, ROR,  8'h00, 0, 8'h80, 1, "ror");
        op(1, ROL,  8'h00, 0, 8'h01, 1, "rol");
        op(1, SHR,  8'h00, 0, 8'h00, 1, "shr_z");

        op(1, LOAD, 8'hFF, 0, 8'hFF, 0, "ld_ff");
        op(1, INC,  8'h00, 0, 8'h00, 1, "inc_wrap");
        op(1, DEC,  8'h00, 0, 8'hFF, 1, "dec_wrap");
        op(1, HOLD, 8'h12, 1, 8'hFF, 1, "mode_hold");

        op(1, LOAD, 8'h07, 0, 8'h07, 0, "ld_07");
        op(1, INC,  8'h00, 0, 8'h08, 0, "inc_08");
        op(1, DEC,  8'h00, 0, 8'h07, 0, "dec_07");

        op(1, LOAD, 8'h00, 0, 8'h00, 0, "ld_00");
        op(1, INC,  8'h00, 0, 8'h01, 0, "inc1");
        op(1, INC,  8'h00, 0, 8'h02, 0, "inc2");

        // Async reset asserted between edges while INC is still selected.
        @(negedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        chk("mid_rst.out", out, 8'h00);
        chk("mid_rst.carry", {7'd0, carry}, 8'h00);
        chk("mid_rst.zero", {7'd0, zero}, 8'h01);
        @(negedge clk);
        en   = 1'b0;
        rst_ = 1'b1;
        op(1, INC, 8'h00, 0, 8'h01, 0, "post_rst");

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
